// File: rtl/mem_arbiter_if.sv
// Bundle of fetch-port, data-port and ram-side signals for mem_arbiter.
// Latency: none; wires only.
// Backpressure: requests are level signals held until the matching ack pulse; the ram stalls via ram_busy.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_adr;
  logic        if_ack;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_adr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;

  logic        ram_start;
  logic [31:0] ram_adr;
  logic        ram_load;
  logic [31:0] ram_in;
  logic [31:0] ram_out;
  logic        ram_busy;

  // Arbiter side.
  modport slave (
    input  if_req, if_adr, d_req, d_we, d_adr, d_wdata, ram_out, ram_busy,
    output if_ack, if_rdata, d_ack, d_rdata, d_err,
    output ram_start, ram_adr, ram_load, ram_in
  );

  // Requester and ram side.
  modport master (
    output if_req, if_adr, d_req, d_we, d_adr, d_wdata, ram_out, ram_busy,
    input  if_ack, if_rdata, d_ack, d_rdata, d_err,
    input  ram_start, ram_adr, ram_load, ram_in
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-access ram; optional round-robin via MEM_ARBITER_RR_EN.
// Latency: ack 3 cycles after the request is seen in IDLE (2 for out-of-range), plus ram_busy stall cycles.
// Backpressure: one access in flight; losers keep req high and wait; ram_busy holds the FSM in WAIT.
module mem_arbiter #(
  parameter int MEM_SIZE = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  localparam logic [31:0] MEM_LIM = 32'(MEM_SIZE);

  state_t      state;
  logic        gnt_d;     // 1 = data port owns the access in flight
  logic        lat_we;    // access in flight is a store
  logic        lat_oor;   // access in flight is out of range, ram is bypassed
  logic        pick_d;
  logic [31:0] sel_adr;
  logic        sel_oor;

`ifdef MEM_ARBITER_RR_EN
  logic        last_d;    // 1 = data port was granted most recently

  // Round-robin choice: under contention the port not granted last time wins.
  always_comb begin
    pick_d = bus.d_req;
    if (bus.d_req && bus.if_req) begin
      pick_d = ~last_d;
    end
  end
`else
  // Fixed priority: data port wins whenever it requests.
  always_comb begin
    pick_d = bus.d_req;
  end
`endif

  // Address of the would-be grantee and its range check.
  always_comb begin
    sel_adr = pick_d ? bus.d_adr : bus.if_adr;
    sel_oor = (sel_adr >= MEM_LIM);
  end

  // Access sequencer: IDLE -> ISSUE -> WAIT -> ACK, or IDLE -> ISSUE -> ACK when out of range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      gnt_d         <= 1'b0;
      lat_we        <= 1'b0;
      lat_oor       <= 1'b0;
      bus.ram_start <= 1'b0;
      bus.ram_adr   <= '0;
      bus.ram_load  <= 1'b0;
      bus.ram_in    <= '0;
      bus.if_ack    <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_ack     <= 1'b0;
      bus.d_rdata   <= '0;
      bus.d_err     <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
      last_d        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.d_req || bus.if_req) begin
            gnt_d   <= pick_d;
            lat_we  <= pick_d & bus.d_we;
            lat_oor <= sel_oor;
            // Out-of-range accesses never touch the ram; a store is simply dropped.
            if (!sel_oor) begin
              bus.ram_start <= 1'b1;
              bus.ram_adr   <= sel_adr;
              bus.ram_load  <= pick_d & bus.d_we;
              bus.ram_in    <= pick_d ? bus.d_wdata : 32'd0;
            end
`ifdef MEM_ARBITER_RR_EN
            last_d <= pick_d;
`endif
            state <= ISSUE;
          end
        end
        ISSUE: begin
          bus.ram_start <= 1'b0;
          if (lat_oor) begin
            if (gnt_d) begin
              bus.d_ack   <= 1'b1;
              bus.d_rdata <= '0;
            end else begin
              bus.if_ack   <= 1'b1;
              bus.if_rdata <= '0;
            end
            bus.d_err <= 1'b1;
            state     <= ACK;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!bus.ram_busy) begin
            bus.ram_load <= 1'b0;
            if (gnt_d) begin
              bus.d_ack   <= 1'b1;
              bus.d_rdata <= lat_we ? 32'd0 : bus.ram_out;
            end else begin
              bus.if_ack   <= 1'b1;
              bus.if_rdata <= bus.ram_out;
            end
            bus.d_err <= 1'b0;
            state     <= ACK;
          end
        end
        ACK: begin
          bus.if_ack <= 1'b0;
          bus.d_ack  <= 1'b0;
          bus.d_err  <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences, randomized traffic vs. a transaction model.
// Latency: checks ack timing per access against the expected cycle counts.
// Backpressure: exercises ram_busy stalls and fetch/data contention.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  mem_arbiter_if bif();

  mem_arbiter #(.MEM_SIZE(1024)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] initval(input int a);
    if (a == 4) return 32'h1234_5678;
    return (32'(a) * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  // Simple ram: combinational read, write on a start strobe with load set.
  logic [31:0] ram [0:1023];
  logic        ram_inited = 1'b0;

  always_comb bif.ram_out = ram[bif.ram_adr[9:0]];

  always @(posedge clk) begin
    if (!ram_inited) begin
      for (int i = 0; i < 1024; i++) ram[i] <= initval(i);
      ram_inited <= 1'b1;
    end else if (bif.ram_start && bif.ram_load) begin
      ram[bif.ram_adr[9:0]] <= bif.ram_in;
    end
  end

  // Reference model state: memory image and last-granted port.
  logic [31:0] mdl [0:1023];
  bit          mdl_last_d;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Raise requests, observe until an ack or timeout, then drop requests and return in an IDLE cycle.
  task automatic txn(input bit dq, input bit iq, input bit we,
                     input logic [31:0] dadr, input logic [31:0] iadr, input logic [31:0] wd,
                     input int busy, input logic [31:0] exp_adr,
                     output bit got_d, output bit got_i, output int lat,
                     output logic [31:0] rd, output bit err, output int starts,
                     output bit load_seen, output bit adr_bad);
    got_d = 0; got_i = 0; lat = 0; rd = '0; err = 0; starts = 0; load_seen = 0; adr_bad = 0;
    bif.d_req = dq; bif.d_we = we; bif.d_adr = dadr; bif.d_wdata = wd;
    bif.if_req = iq; bif.if_adr = iadr;
    bif.ram_busy = (busy > 0);
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == busy + 2) bif.ram_busy = 1'b0;
      if (bif.ram_start) starts++;
      if (bif.ram_load) load_seen = 1;
      if (bif.d_ack || bif.if_ack) begin
        got_d = bif.d_ack;
        got_i = bif.if_ack;
        rd    = bif.d_ack ? bif.d_rdata : bif.if_rdata;
        err   = bif.d_err;
        break;
      end
      if (bif.ram_adr !== exp_adr) adr_bad = 1;
    end
    bif.d_req = 0; bif.if_req = 0; bif.ram_busy = 0;
    @(negedge clk);
  endtask

  typedef struct {
    bit          dport;
    bit          we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vt[8];

  // Run one single-port access and compare every observable against expectations.
  task automatic run_one(input string nm, input bit dport, input bit we, input logic [31:0] adr,
                         input logic [31:0] wd, input int busy,
                         input logic [31:0] exp_rd, input bit exp_err, input int exp_lat);
    bit gd, gi, er, ls, ab;
    int lt, st;
    logic [31:0] rd;
    txn(dport, !dport, we, adr, adr, wd, busy, adr, gd, gi, lt, rd, er, st, ls, ab);
    chk({nm, "_ackport"}, {30'd0, gd, gi}, {30'd0, dport, !dport});
    chk({nm, "_lat"}, lt, exp_lat);
    chk({nm, "_rdata"}, rd, exp_rd);
    chk({nm, "_err"}, {31'd0, er}, {31'd0, exp_err});
    chk({nm, "_starts"}, st, exp_err ? 0 : 1);
    chk({nm, "_load"}, {31'd0, ls}, {31'd0, dport && we && !exp_err});
    if (!exp_err) chk({nm, "_adr_stable"}, {31'd0, ab}, 32'd0);
    if (dport && we && !exp_err) mdl[adr[9:0]] = wd;
    mdl_last_d = dport;
  endtask

  initial begin
    bit   seq [2];
    int   n, acks;
    bit   both;
    bit   win1, win2;

    for (int i = 0; i < 1024; i++) mdl[i] = initval(i);
    mdl_last_d = 0;
    bif.if_req = 0; bif.if_adr = '0; bif.d_req = 0; bif.d_we = 0;
    bif.d_adr = '0; bif.d_wdata = '0; bif.ram_busy = 0;
    rst_n = 0;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_ram_start", {31'd0, bif.ram_start}, 32'd0);
    chk("rst_ram_load",  {31'd0, bif.ram_load},  32'd0);
    chk("rst_ram_adr",   bif.ram_adr, 32'd0);
    chk("rst_ram_in",    bif.ram_in,  32'd0);
    chk("rst_acks",      {29'd0, bif.if_ack, bif.d_ack, bif.d_err}, 32'd0);
    chk("rst_if_rdata",  bif.if_rdata, 32'd0);
    chk("rst_d_rdata",   bif.d_rdata,  32'd0);
    rst_n = 1;
    @(negedge clk);

    // Directed vectors: fetch, store/load, out-of-range, boundaries.
    vt[0] = '{1'b0, 1'b0, 32'd4,          32'd0,          32'h1234_5678, 1'b0, 3};
    vt[1] = '{1'b1, 1'b1, 32'd2,          32'hDEAD_BEEF,  32'd0,         1'b0, 3};
    vt[2] = '{1'b1, 1'b0, 32'd2,          32'd0,          32'hDEAD_BEEF, 1'b0, 3};
    vt[3] = '{1'b1, 1'b1, 32'd1024,       32'h5555_5555,  32'd0,         1'b1, 2};
    vt[4] = '{1'b1, 1'b0, 32'd0,          32'd0,          initval(0),    1'b0, 3};
    vt[5] = '{1'b0, 1'b0, 32'd1023,       32'd0,          initval(1023), 1'b0, 3};
    vt[6] = '{1'b0, 1'b0, 32'hFFFF_FFFF,  32'd0,          32'd0,         1'b1, 2};
    vt[7] = '{1'b1, 1'b0, 32'd1023,       32'd0,          initval(1023), 1'b0, 3};
    for (int i = 0; i < 8; i++) begin
      run_one($sformatf("vec%0d", i), vt[i].dport, vt[i].we, vt[i].adr, vt[i].wd, 0,
              vt[i].exp_rd, vt[i].exp_err, vt[i].exp_lat);
    end

    // ram_busy held for 5 WAIT cycles stretches the access by 5.
    run_one("busy5", 1'b0, 1'b0, 32'd4, 32'd0, 5, 32'h1234_5678, 1'b0, 8);

    // Contention with both requests held across two accesses.
`ifdef MEM_ARBITER_RR_EN
    win1 = !mdl_last_d;
    win2 = !win1;
`else
    win1 = 1'b1;
    win2 = 1'b1;
`endif
    bif.d_req = 1; bif.d_we = 0; bif.d_adr = 32'd5;
    bif.if_req = 1; bif.if_adr = 32'd6;
    n = 0; both = 0; seq[0] = 0; seq[1] = 0;
    for (int c = 0; c < 30 && n < 2; c++) begin
      @(negedge clk);
      if (bif.d_ack && bif.if_ack) both = 1;
      if (bif.d_ack) begin
        chk("cont_d_rdata", bif.d_rdata, mdl[5]);
        seq[n] = 1'b1; n++;
      end else if (bif.if_ack) begin
        chk("cont_if_rdata", bif.if_rdata, mdl[6]);
        seq[n] = 1'b0; n++;
      end
    end
    bif.d_req = 0; bif.if_req = 0;
    @(negedge clk);
    chk("cont_count", n, 2);
    chk("cont_first",  {31'd0, seq[0]}, {31'd0, win1});
    chk("cont_second", {31'd0, seq[1]}, {31'd0, win2});
    chk("cont_excl",   {31'd0, both}, 32'd0);
    mdl_last_d = win2;

    // Reset asserted while the access is stalled in WAIT.
    bif.if_req = 1; bif.if_adr = 32'd7; bif.ram_busy = 1;
    repeat (3) @(negedge clk);
    rst_n = 0;
    #1;
    chk("midrst_ram_adr", bif.ram_adr, 32'd0);
    chk("midrst_ctrl", {28'd0, bif.ram_start, bif.ram_load, bif.if_ack, bif.d_ack}, 32'd0);
    chk("midrst_err", {31'd0, bif.d_err}, 32'd0);
    chk("midrst_rdata", bif.if_rdata | bif.d_rdata | bif.ram_in, 32'd0);
    bif.if_req = 0; bif.ram_busy = 0;
    mdl_last_d = 0;
    @(negedge clk);
    rst_n = 1;
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (bif.if_ack || bif.d_ack || bif.ram_start) acks++;
    end
    chk("midrst_no_ack", acks, 0);
    run_one("postrst", 1'b0, 1'b0, 32'd7, 32'd0, 0, mdl[7], 1'b0, 3);

    // Randomized traffic against the transaction-level model.
    for (int t = 0; t < 150; t++) begin
      int          mode, r, lt, st, exp_lat;
      logic [31:0] dadr, iadr, wd, rd, adr_w, exp_rd;
      bit          we, win, oor, gd, gi, er, ls, ab;
      mode = $urandom_range(0, 2);
      r = $urandom_range(0, 9);
      dadr = (r == 0) ? 32'd1024 + $urandom_range(0, 100) : (r == 1) ? 32'hFFFF_FFFF : $urandom_range(0, 15);
      r = $urandom_range(0, 9);
      iadr = (r == 0) ? 32'd1024 + $urandom_range(0, 100) : $urandom_range(0, 15);
      we = $urandom_range(0, 1);
      wd = $urandom;
      if (mode == 0) win = 1;
      else if (mode == 1) win = 0;
`ifdef MEM_ARBITER_RR_EN
      else win = !mdl_last_d;
`else
      else win = 1;
`endif
      adr_w   = win ? dadr : iadr;
      oor     = (adr_w >= 32'd1024);
      exp_lat = oor ? 2 : 3;
      exp_rd  = (oor || (win && we)) ? 32'd0 : mdl[adr_w[9:0]];
      txn(mode != 1, mode != 0, we, dadr, iadr, wd, 0, adr_w, gd, gi, lt, rd, er, st, ls, ab);
      chk($sformatf("rnd%0d_ackport", t), {30'd0, gd, gi}, {30'd0, win, !win});
      chk($sformatf("rnd%0d_lat", t), lt, exp_lat);
      chk($sformatf("rnd%0d_rdata", t), rd, exp_rd);
      chk($sformatf("rnd%0d_err", t), {31'd0, er}, {31'd0, oor});
      chk($sformatf("rnd%0d_starts", t), st, oor ? 0 : 1);
      if (win && we && !oor) mdl[adr_w[9:0]] = wd;
      mdl_last_d = win;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
